// File: rtl/ws2812_rx_decoder_if.sv
// rtl/ws2812_rx_decoder_if.sv - decoded pixel / frame event bundle of the WS2812 receiver
//
// Purpose: carries the decoder results to the consumer (loopback checker or chain monitor).
// Ports (signals):
//   pixel_data   24     last decoded pixel {G,R,B}, first received bit = bit 23
//   pixel_valid  1      1-cycle pulse, pixel_data/pixel_idx updated
//   pixel_idx    PIX_W  index of pixel_data within the current frame
//   frame_done   1      1-cycle pulse on latch (long low) detection
//   frame_err    1      1-cycle pulse with frame_done when a partial pixel was dropped
//   pulse_err    1      1-cycle pulse when a high pulse is too long
// Modports: master = decoder (drives), slave = consumer (observes).

interface ws2812_rx_decoder_if #(
   parameter int PIX_W = 8
);
   logic [23:0]      pixel_data;
   logic             pixel_valid;
   logic [PIX_W-1:0] pixel_idx;
   logic             frame_done;
   logic             frame_err;
   logic             pulse_err;

   modport master (
      output pixel_data,
      output pixel_valid,
      output pixel_idx,
      output frame_done,
      output frame_err,
      output pulse_err
   );

   modport slave (
      input pixel_data,
      input pixel_valid,
      input pixel_idx,
      input frame_done,
      input frame_err,
      input pulse_err
   );
endinterface

// File: rtl/ws2812_rx_decoder.sv
// rtl/ws2812_rx_decoder.sv - WS2812 single-wire receive decoder (pulse width -> GRB pixels)
//
// Purpose: measures the high time of each din pulse, decodes it to a bit, packs 24 bits
//          MSB-first into a GRB pixel and detects the long low time that latches a frame.
// Ports:
//   sys_clk  in   system clock (50 MHz)
//   sys_rst  in   synchronous reset, active-high
//   din      in   asynchronous WS2812 serial line
//   px       ws2812_rx_decoder_if.master: pixel_data, pixel_valid, pixel_idx,
//            frame_done, frame_err, pulse_err

module ws2812_rx_decoder #(
   parameter int BIT_THRESH = 30,
   parameter int MAX_HIGH   = 60,
   parameter int RESET_CYC  = 2500,
   parameter int PIX_W      = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 din,
   ws2812_rx_decoder_if.master  px
);

   localparam int CNT_TOP = (MAX_HIGH > RESET_CYC) ? MAX_HIGH : RESET_CYC;
   localparam int CW      = $clog2(CNT_TOP) + 1;

   localparam logic [CW-1:0] CNT_SAT   = '1;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] THRESH_C  = CW'(BIT_THRESH);
   localparam logic [CW-1:0] HI_LAST   = CW'(MAX_HIGH - 1);
   localparam logic [CW-1:0] LO_LAST   = CW'(RESET_CYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      ERR  = 2'd3
   } state_t;

   // line synchronizer plus edge register
   logic sync1, sync2, line_d;
   logic rise, fall;

   state_t           state, state_n;
   logic [CW-1:0]    hi_cnt, hi_n, hi_inc;
   logic [CW-1:0]    lo_cnt, lo_n, lo_inc;
   logic [4:0]       bit_cnt, bit_n;
   logic [23:0]      shreg, sh_n;
   logic             pend, pend_n;
   logic [PIX_W-1:0] next_idx;
   logic             idx_clr;
   logic             fdone_n, ferr_n, perr_n;

   logic [23:0]      pixel_data_q;
   logic             pixel_valid_q;
   logic [PIX_W-1:0] pixel_idx_q;
   logic             frame_done_q, frame_err_q, pulse_err_q;

   assign rise   = sync2 & ~line_d;
   assign fall   = ~sync2 & line_d;
   assign hi_inc = (hi_cnt == CNT_SAT) ? hi_cnt : hi_cnt + CNT_ONE;
   assign lo_inc = (lo_cnt == CNT_SAT) ? lo_cnt : lo_cnt + CNT_ONE;

   always_comb begin
      state_n = state;
      hi_n    = hi_cnt;
      lo_n    = lo_cnt;
      bit_n   = bit_cnt;
      sh_n    = shreg;
      pend_n  = 1'b0;
      fdone_n = 1'b0;
      ferr_n  = 1'b0;
      perr_n  = 1'b0;
      idx_clr = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_n = HIGH;
               hi_n    = CNT_ONE;
            end
         end
         HIGH: begin
            if (fall) begin
               sh_n = {shreg[22:0], (hi_cnt >= THRESH_C)};
               // 24th bit: the full word sits in shreg now and is published next cycle
               if (bit_cnt == 5'd23) begin
                  bit_n  = 5'd0;
                  pend_n = 1'b1;
               end else begin
                  bit_n = bit_cnt + 5'd1;
               end
               state_n = LOW;
               lo_n    = CNT_ONE;
            end else if (hi_cnt == HI_LAST) begin
               perr_n  = 1'b1;
               sh_n    = '0;
               bit_n   = 5'd0;
               lo_n    = '0;
               state_n = ERR;
            end else begin
               hi_n = hi_inc;
            end
         end
         LOW: begin
            // a rise wins over the latch on the same cycle
            if (rise) begin
               state_n = HIGH;
               hi_n    = CNT_ONE;
            end else if (lo_cnt == LO_LAST) begin
               fdone_n = 1'b1;
               ferr_n  = (bit_cnt != 5'd0);
               bit_n   = 5'd0;
               sh_n    = '0;
               idx_clr = 1'b1;
               state_n = IDLE;
            end else begin
               lo_n = lo_inc;
            end
         end
         ERR: begin
            // only an uninterrupted low run of RESET_CYC cycles recovers
            if (sync2) begin
               lo_n = '0;
            end else if (lo_cnt == LO_LAST) begin
               fdone_n = 1'b1;
               idx_clr = 1'b1;
               state_n = IDLE;
            end else begin
               lo_n = lo_inc;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1         <= 1'b0;
         sync2         <= 1'b0;
         line_d        <= 1'b0;
         state         <= IDLE;
         hi_cnt        <= '0;
         lo_cnt        <= '0;
         bit_cnt       <= 5'd0;
         shreg         <= '0;
         pend          <= 1'b0;
         next_idx      <= '0;
         pixel_data_q  <= '0;
         pixel_valid_q <= 1'b0;
         pixel_idx_q   <= '0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         pulse_err_q   <= 1'b0;
      end else begin
         sync1         <= din;
         sync2         <= sync1;
         line_d        <= sync2;
         state         <= state_n;
         hi_cnt        <= hi_n;
         lo_cnt        <= lo_n;
         bit_cnt       <= bit_n;
         shreg         <= sh_n;
         pend          <= pend_n;
         pixel_valid_q <= pend;
         frame_done_q  <= fdone_n;
         frame_err_q   <= ferr_n;
         pulse_err_q   <= perr_n;
         // pend and idx_clr are never both set: a latch needs long low after the last fall
         if (pend) begin
            pixel_data_q <= shreg;
            pixel_idx_q  <= next_idx;
            next_idx     <= next_idx + 1'b1;
         end else if (idx_clr) begin
            next_idx <= '0;
         end
      end
   end

   assign px.pixel_data  = pixel_data_q;
   assign px.pixel_valid = pixel_valid_q;
   assign px.pixel_idx   = pixel_idx_q;
   assign px.frame_done  = frame_done_q;
   assign px.frame_err   = frame_err_q;
   assign px.pulse_err   = pulse_err_q;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// tb/tb_ws2812_rx_decoder.sv - scoreboard bench for ws2812_rx_decoder

module tb_ws2812_rx_decoder;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic din     = 1'b0;

   ws2812_rx_decoder_if #(.PIX_W(8)) px ();

   ws2812_rx_decoder #(
      .BIT_THRESH (30),
      .MAX_HIGH   (60),
      .RESET_CYC  (2500),
      .PIX_W      (8)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .din     (din),
      .px      (px)
   );

   always #10 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] pix_q[$];   // {idx, data}
   bit          frm_q[$];   // expected frame_err per frame_done
   int last_fall  = 0;
   int perr_rise  = 0;
   int perr_seen  = 0;
   int tb_idx     = 0;
   int tb_bits    = 0;
   logic [31:0] mon_e;
   bit          mon_f;

   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (px.pixel_valid) begin
            if (pix_q.size() == 0) begin
               chk("pix_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = pix_q.pop_front();
               chk("pix_data", {8'd0, px.pixel_data}, {8'd0, mon_e[23:0]});
               chk("pix_idx", {24'd0, px.pixel_idx}, {24'd0, mon_e[31:24]});
               chk("pix_latency", cyc - last_fall, 32'd4);
            end
         end
         if (px.frame_done) begin
            if (frm_q.size() == 0) begin
               chk("frame_unexpected", 32'd1, 32'd0);
            end else begin
               mon_f = frm_q.pop_front();
               chk("frame_err", {31'd0, px.frame_err}, {31'd0, mon_f});
            end
         end else if (px.frame_err) begin
            chk("frame_err_alone", 32'd1, 32'd0);
         end
         if (px.pulse_err) begin
            chk("perr_latency", cyc - perr_rise, 32'd62);
            perr_seen++;
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic pulse(input int hi);
      din = 1'b1;
      wait_cyc(hi);
      din = 1'b0;
      last_fall = cyc;
      wait_cyc(62 - hi);
      tb_bits = (tb_bits + 1) % 24;
   endtask

   task automatic send_bit(input bit b);
      pulse(b ? 40 : 20);
   endtask

   task automatic expect_pixel(input logic [23:0] w);
      logic [7:0] idx8;
      idx8 = tb_idx[7:0];
      pix_q.push_back({idx8, w});
      tb_idx = (tb_idx + 1) % 256;
   endtask

   task automatic send_pixel(input logic [23:0] w);
      expect_pixel(w);
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic latch();
      frm_q.push_back(tb_bits != 0);
      din = 1'b0;
      wait_cyc(2520);
      tb_idx  = 0;
      tb_bits = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_data"}, {8'd0, px.pixel_data}, 32'd0);
      chk({tag, "_flags"},
          {20'd0, px.pixel_valid, px.pixel_idx, px.frame_done, px.frame_err, px.pulse_err},
          32'd0);
   endtask

   initial begin
      logic [23:0] sw;
      wait_cyc(4);
      check_outputs_zero("reset");
      sys_rst = 1'b0;
      wait_cyc(5);

      // single pixel, clean frame
      send_pixel(24'hFF00A5);
      latch();

      // three pixels back-to-back, then a new frame restarting at index 0
      send_pixel(24'h123456);
      send_pixel(24'hABCDEF);
      send_pixel(24'h000001);
      latch();
      send_pixel(24'hC0FFEE);
      latch();

      // threshold boundaries: glitch(1)->0, 59->1, 29->0, 30->1
      sw = 24'h9E3C70;
      expect_pixel(24'h9E3C75);
      for (int i = 23; i >= 4; i--) send_bit(sw[i]);
      pulse(1);
      pulse(59);
      pulse(29);
      pulse(30);
      latch();

      // partial pixel dropped at the latch, then a clean pixel
      for (int i = 0; i < 10; i++) send_bit(i[0]);
      latch();
      send_pixel(24'h3C5AA5);
      latch();

      // over-long pulse: error, following pulses ignored until a full low run
      perr_rise = cyc;
      din = 1'b1;
      wait_cyc(100);
      din = 1'b0;
      wait_cyc(30);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      tb_bits = 0;
      latch();

      // reset in the middle of a pixel
      for (int i = 0; i < 12; i++) send_bit(i[1]);
      sys_rst = 1'b1;
      wait_cyc(2);
      check_outputs_zero("reset_mid");
      sys_rst = 1'b0;
      tb_bits = 0;
      tb_idx  = 0;
      wait_cyc(5);
      send_pixel(24'h5A5A5A);
      latch();

      wait_cyc(10);
      chk("pix_queue_empty", pix_q.size(), 32'd0);
      chk("frame_queue_empty", frm_q.size(), 32'd0);
      chk("perr_count", perr_seen, 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #(20 * 200000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
